// File: rtl/voice_allocator.sv
// Polyphonic voice allocator: assigns note-on/note-off events to a fixed voice array,
// stealing the oldest voice when full and forcing a key-off gap on steal or retrigger.
module voice_allocator #(
   parameter int NUM_VOICES    = 4,
   parameter int AGE_W         = 8,
   parameter int RETRIG_CYCLES = 16
) (
   input  logic                    Clk,
   input  logic                    Reset,
   input  logic                    ev_valid,
   output logic                    ev_ready,
   input  logic                    ev_on,
   input  logic [6:0]              ev_note,
   output logic [8*NUM_VOICES-1:0] voice_note,
   output logic [NUM_VOICES-1:0]   voice_key_on,
   output logic [4:0]              active_count
);

   localparam int IDX_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_VOICES - 1);
   localparam logic [AGE_W-1:0] AGE_MAX   = '1;
   localparam logic [7:0]       GAP_RELOAD = 8'(RETRIG_CYCLES - 1);

   typedef enum logic [1:0] {IDLE, SCAN, APPLY, GAP} state_e;

   state_e state_q, state_d;

   logic                               on_q, on_d;
   logic [6:0]                         lnote_q, lnote_d;
   logic [IDX_W-1:0]                   idx_q, idx_d;
   logic                               match_hit_q, match_hit_d;
   logic [IDX_W-1:0]                   match_idx_q, match_idx_d;
   logic                               free_hit_q, free_hit_d;
   logic [IDX_W-1:0]                   free_idx_q, free_idx_d;
   logic [IDX_W-1:0]                   old_idx_q, old_idx_d;
   logic [AGE_W-1:0]                   old_age_q, old_age_d;
   logic [NUM_VOICES-1:0]              mask_q, mask_d;
   logic [IDX_W-1:0]                   tgt_q, tgt_d;
   logic [7:0]                         gap_q, gap_d;
   logic [NUM_VOICES-1:0][7:0]         note_q, note_d;
   logic [NUM_VOICES-1:0]              key_q, key_d;
   logic [NUM_VOICES-1:0][AGE_W-1:0]   age_q, age_d;
   logic [4:0]                         count_q, count_d;

   logic             do_assign;
   logic [IDX_W-1:0] assign_idx;

   // State register.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state_q <= IDLE;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so every register
         // samples the pre-edge values regardless of statement order.
         state_q <= state_d;
      end
   end

   // Next-state logic.
   always_comb begin
      // NOTE: a default on every path keeps combinational blocks from inferring latches.
      state_d = state_q;
      case (state_q)
         IDLE:  if (ev_valid) state_d = SCAN;
         SCAN:  if (idx_q == LAST_IDX) state_d = APPLY;
         APPLY: state_d = (on_q && (match_hit_q || !free_hit_q)) ? GAP : IDLE;
         GAP:   if (gap_q == 8'd0) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Output decode.
   always_comb begin
      ev_ready = (state_q == IDLE);
   end

   // Datapath next-state: scan candidates, apply, gap countdown, ageing.
   always_comb begin
      on_d        = on_q;
      lnote_d     = lnote_q;
      idx_d       = idx_q;
      match_hit_d = match_hit_q;
      match_idx_d = match_idx_q;
      free_hit_d  = free_hit_q;
      free_idx_d  = free_idx_q;
      old_idx_d   = old_idx_q;
      old_age_d   = old_age_q;
      mask_d      = mask_q;
      tgt_d       = tgt_q;
      gap_d       = gap_q;
      note_d      = note_q;
      key_d       = key_q;
      age_d       = age_q;
      do_assign   = 1'b0;
      assign_idx  = '0;

      case (state_q)
         IDLE: begin
            if (ev_valid) begin
               on_d        = ev_on;
               lnote_d     = ev_note;
               idx_d       = '0;
               match_hit_d = 1'b0;
               match_idx_d = '0;
               free_hit_d  = 1'b0;
               free_idx_d  = '0;
               old_idx_d   = '0;
               old_age_d   = '0;
               mask_d      = '0;
            end
         end
         SCAN: begin
            if (key_q[idx_q] && note_q[idx_q] == {1'b0, lnote_q}) begin
               mask_d[idx_q] = 1'b1;
               if (!match_hit_q) begin
                  match_hit_d = 1'b1;
                  match_idx_d = idx_q;
               end
            end
            if (!key_q[idx_q] && !free_hit_q) begin
               free_hit_d = 1'b1;
               free_idx_d = idx_q;
            end
            // Strict compare keeps the lowest index on equal ages.
            if (age_q[idx_q] > old_age_q) begin
               old_age_d = age_q[idx_q];
               old_idx_d = idx_q;
            end
            idx_d = idx_q + IDX_W'(1);
         end
         APPLY: begin
            if (on_q) begin
               if (match_hit_q) begin
                  key_d[match_idx_q] = 1'b0;
                  tgt_d              = match_idx_q;
                  gap_d              = GAP_RELOAD;
               end else if (free_hit_q) begin
                  do_assign  = 1'b1;
                  assign_idx = free_idx_q;
               end else begin
                  key_d[old_idx_q] = 1'b0;
                  tgt_d            = old_idx_q;
                  gap_d            = GAP_RELOAD;
               end
            end else begin
               key_d = key_q & ~mask_q;
            end
         end
         GAP: begin
            if (gap_q == 8'd0) begin
               do_assign  = 1'b1;
               assign_idx = tgt_q;
            end else begin
               gap_d = gap_q - 8'd1;
            end
         end
         default: ;
      endcase

      if (do_assign) begin
         for (int i = 0; i < NUM_VOICES; i++) begin
            if (assign_idx == IDX_W'(i)) begin
               note_d[i] = {1'b0, lnote_q};
               key_d[i]  = 1'b1;
               age_d[i]  = '0;
            end else if (key_q[i] && age_q[i] != AGE_MAX) begin
               age_d[i] = age_q[i] + AGE_W'(1);
            end
         end
      end

      count_d = '0;
      for (int i = 0; i < NUM_VOICES; i++) begin
         count_d = count_d + 5'(key_q[i]);
      end
   end

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         on_q        <= 1'b0;
         lnote_q     <= '0;
         idx_q       <= '0;
         match_hit_q <= 1'b0;
         match_idx_q <= '0;
         free_hit_q  <= 1'b0;
         free_idx_q  <= '0;
         old_idx_q   <= '0;
         old_age_q   <= '0;
         mask_q      <= '0;
         tgt_q       <= '0;
         gap_q       <= '0;
         // NOTE: the per-voice note and age arrays are reset because they drive
         // outputs and steal decisions directly; they are small registers, not RAM.
         note_q      <= '0;
         key_q       <= '0;
         age_q       <= '0;
         count_q     <= '0;
      end else begin
         on_q        <= on_d;
         lnote_q     <= lnote_d;
         idx_q       <= idx_d;
         match_hit_q <= match_hit_d;
         match_idx_q <= match_idx_d;
         free_hit_q  <= free_hit_d;
         free_idx_q  <= free_idx_d;
         old_idx_q   <= old_idx_d;
         old_age_q   <= old_age_d;
         mask_q      <= mask_d;
         tgt_q       <= tgt_d;
         gap_q       <= gap_d;
         note_q      <= note_d;
         key_q       <= key_d;
         age_q       <= age_d;
         count_q     <= count_d;
      end
   end

   assign voice_note   = note_q;
   assign voice_key_on = key_q;
   assign active_count = count_q;

endmodule
